seq_checker: RTL

- Downstream consumer of the 4-bit even-sequence counter, which produces the repeating sequence 2,4,6,4,8.
- Samples the counter value on each enabled clock and tracks the expected position with an FSM.
- Flags matches and mismatches, counts completed periods and errors (saturating), and drives a registered 7-segment display of the last sampled value.
- Sits between the counter and the board I/O (LEDs, 7-seg).

---
 rtl/seq_checker_pkg.sv | 48 ++++
 rtl/seq_checker_if.sv | 28 ++
 rtl/seq_checker_hex_to_seg7.sv | 31 +++
 rtl/seq_checker.sv | 91 +++++++++
 4 files changed

// File: rtl/seq_checker_pkg.sv
// Shared definitions for the even-sequence checker: FSM encoding,
// the symbols of the 2,4,6,4,8 period and the blank display code.
package seq_checker_pkg;

  // Each state names the last accepted symbol; HUNT means unsynchronised.
  typedef enum logic [2:0] {
    HUNT = 3'd0,
    S2   = 3'd1,
    S4A  = 3'd2,
    S6   = 3'd3,
    S4B  = 3'd4,
    S8   = 3'd5
  } state_t;

  localparam logic [3:0] SYM2 = 4'h2;
  localparam logic [3:0] SYM4 = 4'h4;
  localparam logic [3:0] SYM6 = 4'h6;
  localparam logic [3:0] SYM8 = 4'h8;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Symbol that must arrive next when the FSM sits in state s.
  function automatic logic [3:0] expected_sym(input state_t s);
    case (s)
      HUNT:    expected_sym = SYM2;
      S2:      expected_sym = SYM4;
      S4A:     expected_sym = SYM6;
      S6:      expected_sym = SYM4;
      S4B:     expected_sym = SYM8;
      S8:      expected_sym = SYM2;
      default: expected_sym = SYM2;
    endcase
  endfunction

  // State reached when the expected symbol is accepted in state s.
  function automatic state_t advance(input state_t s);
    case (s)
      HUNT:    advance = S2;
      S2:      advance = S4A;
      S4A:     advance = S6;
      S6:      advance = S4B;
      S4B:     advance = S8;
      S8:      advance = S2;
      default: advance = HUNT;
    endcase
  endfunction

endpackage

// File: rtl/seq_checker_if.sv
// Bus between the counter/board side and the checker.
// Handshake: EN is a one-way sample strobe with no back-pressure; D is
// consumed on every rising CLK edge where EN=1 (and CLR=0), and ignored
// otherwise. All outputs are registered and update on that same edge.
interface seq_checker_if #(parameter int CNT_W = 8);
  import seq_checker_pkg::*;

  logic             EN;
  logic             CLR;
  logic [3:0]       D;
  logic [6:0]       SEG;
  logic             MATCH;
  logic             ERR;
  logic             LOCKED;
  logic [CNT_W-1:0] PERIODS;
  logic [CNT_W-1:0] ERRS;
  state_t           STATE;   // debug view of the FSM state

  modport master (
    output EN, CLR, D,
    input  SEG, MATCH, ERR, LOCKED, PERIODS, ERRS, STATE
  );

  modport slave (
    input  EN, CLR, D,
    output SEG, MATCH, ERR, LOCKED, PERIODS, ERRS, STATE
  );
endinterface

// File: rtl/seq_checker_hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment decoder, bits {g,f,e,d,c,b,a}.
module hex_to_seg7 (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Full 16-entry lookup; b and d are lower-case glyphs.
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seq_checker.sv
// Checks a stream of counter values against the repeating 2,4,6,4,8
// period, pulses MATCH/ERR per sample, keeps saturating period and error
// counts and shows the last sampled value on a registered 7-seg display.
module seq_checker
  import seq_checker_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  seq_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [6:0]       seg_q, seg_d;
  logic             match_q, match_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] periods_q, periods_d;
  logic [CNT_W-1:0] errs_q, errs_d;
  logic [6:0]       seg_dec;

  hex_to_seg7 u_dec (
    .hex (bus.D),
    .seg (seg_dec)
  );

  // Next-state and output logic; CLR beats EN, EN=0 holds everything but the pulses.
  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    match_d   = 1'b0;
    err_d     = 1'b0;
    periods_d = periods_q;
    errs_d    = errs_q;
    if (bus.CLR) begin
      state_d   = HUNT;
      periods_d = '0;
      errs_d    = '0;
    end else if (bus.EN) begin
      seg_d = seg_dec;
      if (bus.D == expected_sym(state_q)) begin
        match_d = 1'b1;
        state_d = advance(state_q);
        if (state_q == S8 && periods_q != CNT_MAX) begin
          periods_d = periods_q + 1'b1;
        end
      end else if (state_q != HUNT) begin
        // Lost sync: a 2 restarts the period at once, anything else hunts.
        err_d   = 1'b1;
        state_d = (bus.D == SYM2) ? S2 : HUNT;
        if (errs_q != CNT_MAX) begin
          errs_d = errs_q + 1'b1;
        end
      end
    end
    locked_d = (state_d != HUNT);
  end

  // FSM, display and counters, asynchronously cleared to the idle/blank state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= HUNT;
      seg_q     <= SEG_OFF;
      match_q   <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      periods_q <= '0;
      errs_q    <= '0;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      match_q   <= match_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      periods_q <= periods_d;
      errs_q    <= errs_d;
    end
  end

  assign bus.SEG     = seg_q;
  assign bus.MATCH   = match_q;
  assign bus.ERR     = err_q;
  assign bus.LOCKED  = locked_q;
  assign bus.PERIODS = periods_q;
  assign bus.ERRS    = errs_q;
  assign bus.STATE   = state_q;

endmodule
